// File: rtl/conv_relu_pool.sv
// Output stage of the convolution layer: sweeps the result buffer, applies ReLU,
// and reduces each 2x2 window (stride 2) to its maximum, streaming pooled words out.
module conv_relu_pool #(
    parameter int DataWidth   = 32,
    parameter int MaxRowWidth = 9,
    parameter int MaxColWidth = 9,
    parameter int AddrWidth   = 16
) (
    input  logic                   Clk,
    input  logic                   Rst_n,
    input  logic                   start,
    input  logic [MaxRowWidth-1:0] row_in,
    input  logic [MaxColWidth-1:0] col_in,
    output logic [AddrWidth-1:0]   rd_addr,
    input  logic [DataWidth-1:0]   rd_data,
    output logic [DataWidth-1:0]   data_out,
    output logic [AddrWidth-1:0]   out_index,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_LAST,
        ST_OUT,
        ST_DONE
    } state_t;

    state_t state_reg, state_next;

    logic [MaxRowWidth-1:0] prows_reg;
    logic [MaxRowWidth-1:0] pr_reg;
    logic [MaxColWidth-1:0] pcols_reg;
    logic [MaxColWidth-1:0] pc_reg;
    logic [AddrWidth-1:0]   stride_reg;
    logic [AddrWidth-1:0]   row_base_reg;
    logic [AddrWidth-1:0]   win_base_reg;
    logic [AddrWidth-1:0]   win_idx_reg;
    logic [1:0]             k_reg;
    logic [DataWidth-1:0]   max_reg;

    logic [MaxRowWidth-1:0] start_prows;
    logic [MaxColWidth-1:0] start_pcols;
    logic                   degenerate;
    logic                   handshake;
    logic                   last_col;
    logic                   last_row;
    logic                   last_win;
    logic [DataWidth-1:0]   relu_word;
    logic [DataWidth-1:0]   fold_word;
    logic [AddrWidth-1:0]   next_row_base;
    logic [AddrWidth-1:0]   next_col_base;

    assign start_prows   = row_in >> 1;
    assign start_pcols   = col_in >> 1;
    assign degenerate    = (start_prows == '0) || (start_pcols == '0);
    assign handshake     = out_valid & out_ready;
    assign last_col      = (pc_reg == pcols_reg - MaxColWidth'(1));
    assign last_row      = (pr_reg == prows_reg - MaxRowWidth'(1));
    assign last_win      = last_col & last_row;

    // Sign bit set covers negatives, -0 and negative NaNs; all collapse to +0.
    assign relu_word     = rd_data[DataWidth-1] ? '0 : rd_data;
    // Non-negative IEEE words order the same as their unsigned bit patterns.
    assign fold_word     = (relu_word > max_reg) ? relu_word : max_reg;
    assign next_row_base = row_base_reg + {stride_reg[AddrWidth-2:0], 1'b0};
    assign next_col_base = win_base_reg + AddrWidth'(2);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = degenerate ? ST_DONE : ST_READ;
                end
            end
            ST_READ: begin
                if (k_reg == 2'd3) begin
                    state_next = ST_LAST;
                end
            end
            ST_LAST: state_next = ST_OUT;
            ST_OUT: begin
                if (handshake) begin
                    state_next = last_win ? ST_DONE : ST_READ;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            prows_reg    <= '0;
            pcols_reg    <= '0;
            pr_reg       <= '0;
            pc_reg       <= '0;
            stride_reg   <= '0;
            row_base_reg <= '0;
            win_base_reg <= '0;
            win_idx_reg  <= '0;
            k_reg        <= '0;
            max_reg      <= '0;
            rd_addr      <= '0;
            data_out     <= '0;
            out_index    <= '0;
            out_valid    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        prows_reg    <= start_prows;
                        pcols_reg    <= start_pcols;
                        stride_reg   <= AddrWidth'(col_in);
                        pr_reg       <= '0;
                        pc_reg       <= '0;
                        row_base_reg <= '0;
                        win_base_reg <= '0;
                        win_idx_reg  <= '0;
                        k_reg        <= '0;
                        max_reg      <= '0;
                        rd_addr      <= '0;
                        busy         <= 1'b1;
                    end
                end
                ST_READ: begin
                    k_reg <= k_reg + 2'd1;
                    // rd_data lags rd_addr by one cycle, so word k-1 arrives at step k.
                    if (k_reg != 2'd0) begin
                        max_reg <= fold_word;
                    end
                    case (k_reg)
                        2'd0:    rd_addr <= rd_addr + AddrWidth'(1);
                        2'd1:    rd_addr <= rd_addr + stride_reg - AddrWidth'(1);
                        2'd2:    rd_addr <= rd_addr + AddrWidth'(1);
                        default: rd_addr <= rd_addr;
                    endcase
                end
                ST_LAST: begin
                    data_out  <= fold_word;
                    out_index <= win_idx_reg;
                    out_valid <= 1'b1;
                end
                ST_OUT: begin
                    if (handshake) begin
                        out_valid <= 1'b0;
                        max_reg   <= '0;
                        k_reg     <= '0;
                        if (!last_win) begin
                            win_idx_reg <= win_idx_reg + AddrWidth'(1);
                            if (last_col) begin
                                pc_reg       <= '0;
                                pr_reg       <= pr_reg + MaxRowWidth'(1);
                                row_base_reg <= next_row_base;
                                win_base_reg <= next_row_base;
                                rd_addr      <= next_row_base;
                            end else begin
                                pc_reg       <= pc_reg + MaxColWidth'(1);
                                win_base_reg <= next_col_base;
                                rd_addr      <= next_col_base;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_relu_pool.sv
// Self-checking bench for conv_relu_pool: table of single-window vectors plus
// hand-written sweeps, with a scoreboard queue checked on every output handshake.
module tb_conv_relu_pool;

    localparam int DW = 32;
    localparam int RW = 9;
    localparam int CW = 9;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [RW-1:0] row_in = '0;
    logic [CW-1:0] col_in = '0;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data = '0;
    logic [DW-1:0] data_out;
    logic [AW-1:0] out_index;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          busy;
    logic          done;

    logic [DW-1:0] mem [0:255];

    typedef struct {
        logic [31:0] data;
        logic [15:0] idx;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
        logic [31:0] w3;
        logic [31:0] expv;
    } vec_t;

    exp_t        sb[$];
    vec_t        tbl[7];
    logic [31:0] fl[16];
    int          tests_run = 0;
    int          tests_failed = 0;

    conv_relu_pool #(
        .DataWidth  (DW),
        .MaxRowWidth(RW),
        .MaxColWidth(CW),
        .AddrWidth  (AW)
    ) dut (
        .Clk      (clk),
        .Rst_n    (rst_n),
        .start    (start),
        .row_in   (row_in),
        .col_in   (col_in),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .data_out (data_out),
        .out_index(out_index),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // One-cycle-latency buffer model.
    always @(posedge clk) rd_data <= mem[rd_addr[7:0]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests_run++;
        if (act !== expv) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
        end
    endtask

    task automatic push_exp(input logic [31:0] d, input logic [15:0] i);
        exp_t e;
        e.data = d;
        e.idx  = i;
        sb.push_back(e);
    endtask

    // Scoreboard: every accepted output word is compared against the queue head.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL unexpected_output: got idx %0d data 0x%08h, expected none",
                         out_index, data_out);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("[TB] out idx=%0d data=0x%08h (exp idx=%0d data=0x%08h)",
                         out_index, data_out, e.idx, e.data);
                check("out_data", data_out, e.data);
                check("out_index", 32'(out_index), 32'(e.idx));
            end
        end
    end

    task automatic start_sweep(input int r, input int c);
        @(posedge clk);
        #1;
        start  = 1'b1;
        row_in = RW'(r);
        col_in = CW'(c);
        @(posedge clk);
        #1;
        start  = 1'b0;
        row_in = RW'($urandom);
        col_in = CW'($urandom);
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", 32'(done), 32'd1);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
        check({tag, "_data_out"}, data_out, 32'd0);
        check({tag, "_out_index"}, 32'(out_index), 32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
    endtask

    // Cycle-by-cycle sweep with out_ready high: addresses, out_valid and done timing.
    task automatic trace_sweep(input int r, input int c);
        int npr, npc, base, pr, pc;
        int off[4];
        npr = r / 2;
        npc = c / 2;
        off[0] = 0;
        off[1] = 1;
        off[2] = c;
        off[3] = c + 1;
        start_sweep(r, c);
        for (int w = 0; w < npr * npc; w++) begin
            pr = w / npc;
            pc = w % npc;
            base = 2 * pr * c + 2 * pc;
            for (int p = 0; p < 6; p++) begin
                @(negedge clk);
                if (w == 0 && p == 0) check("trace_busy_rise", 32'(busy), 32'd1);
                if (p < 4) check($sformatf("trace_addr_w%0d_k%0d", w, p), 32'(rd_addr), 32'(base + off[p]));
                check($sformatf("trace_valid_w%0d_p%0d", w, p), 32'(out_valid), (p == 5) ? 32'd1 : 32'd0);
            end
        end
        @(negedge clk);
        check("trace_done_state_busy", 32'(busy), 32'd1);
        check("trace_done_state_done", 32'(done), 32'd0);
        @(negedge clk);
        check("trace_done_pulse", 32'(done), 32'd1);
        check("trace_busy_fall", 32'(busy), 32'd0);
        $display("[TB] sweep %0dx%0d traced", r, c);
    endtask

    task automatic load_4x4();
        for (int i = 0; i < 16; i++) mem[i] = fl[i];
        mem[0]  = 32'hC0A00000;
        mem[15] = 32'hBF800000;
    endtask

    task automatic push_4x4();
        push_exp(32'h40C00000, 16'd0);
        push_exp(32'h41000000, 16'd1);
        push_exp(32'h41600000, 16'd2);
        push_exp(32'h41700000, 16'd3);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        fl = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
               32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
               32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
               32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000};
        tbl[0] = '{"ascending",    32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40800000};
        tbl[1] = '{"relu_floor",   32'hBF800000, 32'hC0000000, 32'h80000000, 32'hC0400000, 32'h00000000};
        tbl[2] = '{"max_first",    32'h40A00000, 32'h3F800000, 32'hC1200000, 32'h40000000, 32'h40A00000};
        tbl[3] = '{"inf_third",    32'h3F800000, 32'h00000001, 32'h7F800000, 32'h7F7FFFFF, 32'h7F800000};
        tbl[4] = '{"neg_nan",      32'hFFC00000, 32'h00000000, 32'h00000010, 32'h00000003, 32'h00000010};
        tbl[5] = '{"pos_nan",      32'h7F800000, 32'h7FC00000, 32'h3F800000, 32'h7F800000, 32'h7FC00000};
        tbl[6] = '{"all_zero",     32'h00000000, 32'h80000000, 32'h00000000, 32'h00000000, 32'h00000000};
        for (int i = 0; i < 256; i++) mem[i] = '0;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst_n = 1'b1;

        // Single 2x2 window vectors.
        for (int t = 0; t < 7; t++) begin
            mem[0] = tbl[t].w0;
            mem[1] = tbl[t].w1;
            mem[2] = tbl[t].w2;
            mem[3] = tbl[t].w3;
            push_exp(tbl[t].expv, 16'd0);
            start_sweep(2, 2);
            wait_done(50);
            check({"drain_", tbl[t].name}, 32'(sb.size()), 32'd0);
            $display("[TB] vector %s applied", tbl[t].name);
        end

        // Mixed-sign 4x4 sweep.
        load_4x4();
        push_4x4();
        trace_sweep(4, 4);
        check("drain_4x4", 32'(sb.size()), 32'd0);

        // Odd dimensions: last row and column ignored.
        for (int i = 0; i < 16; i++) mem[i] = 32'(i + 100);
        push_exp(32'd104, 16'd0);
        push_exp(32'd110, 16'd1);
        trace_sweep(5, 3);
        check("drain_odd", 32'(sb.size()), 32'd0);

        // Backpressure on a 2x4 sweep.
        for (int i = 0; i < 8; i++) mem[i] = 32'(i + 200);
        push_exp(32'd205, 16'd0);
        push_exp(32'd207, 16'd1);
        out_ready = 1'b0;
        start_sweep(2, 4);
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid_seen", 32'(out_valid), 32'd1);
        for (int i = 0; i < 7; i++) begin
            if (i > 0) @(negedge clk);
            check("bp_valid_hold", 32'(out_valid), 32'd1);
            check("bp_data_hold", data_out, 32'd205);
            check("bp_index_hold", 32'(out_index), 32'd0);
            check("bp_addr_hold", 32'(rd_addr), 32'd5);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_resume_addr", 32'(rd_addr), 32'd2);
        check("bp_valid_cleared", 32'(out_valid), 32'd0);
        wait_done(50);
        check("drain_bp", 32'(sb.size()), 32'd0);
        $display("[TB] backpressure sequence applied");

        // Degenerate dimensions.
        start_sweep(1, 8);
        @(negedge clk);
        check("degen_busy", 32'(busy), 32'd1);
        check("degen_no_done_yet", 32'(done), 32'd0);
        check("degen_no_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("degen_done", 32'(done), 32'd1);
        check("degen_busy_fall", 32'(busy), 32'd0);
        check("degen_no_valid2", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("degen_done_pulse_end", 32'(done), 32'd0);
        $display("[TB] degenerate sequence applied");

        // start pulsed while busy is ignored.
        push_exp(32'd205, 16'd0);
        push_exp(32'd207, 16'd1);
        start_sweep(2, 4);
        repeat (2) @(posedge clk);
        #1;
        start  = 1'b1;
        row_in = RW'(2);
        col_in = CW'(2);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(50);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("ignored_start_busy", 32'(busy), 32'd0);
            check("ignored_start_valid", 32'(out_valid), 32'd0);
        end
        check("drain_ignored_start", 32'(sb.size()), 32'd0);
        $display("[TB] start-while-busy sequence applied");

        // Reset during READ of window 1, then a fresh full sweep.
        load_4x4();
        push_4x4();
        start_sweep(4, 4);
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("midreset");
        check("midreset_first_popped", 32'(sb.size()), 32'd3);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_4x4();
        trace_sweep(4, 4);
        check("drain_after_reset", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
